// File: rtl/mux_scanner_pkg.sv
// Shared types and default build constants for the 4:1 MUX channel scanner.
package mux_scanner_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    SAMPLE = 2'd2
  } scan_state_e;

  localparam int DEF_NUM_CHANNELS  = 4;
  localparam int DEF_SEL_WIDTH     = 2;
  localparam int DEF_SETTLE_CYCLES = 2;
  localparam int DEF_CNT_WIDTH     = 4;

endpackage

// File: rtl/frame_hold_register.sv
// One-entry valid/ready holding register; a load that arrives while an
// untransferred frame is held is dropped and latches a sticky overrun flag.
module frame_hold_register #(
  parameter int W = 4
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         load_i,
  input  logic [W-1:0] data_i,
  input  logic         ready_i,
  output logic [W-1:0] data_o,
  output logic         valid_o,
  output logic         overrun_o
);

  logic [W-1:0] data_q;
  logic         valid_q;
  logic         overrun_q;
  logic         xfer;
  logic         blocked;

  assign xfer    = valid_q && ready_i;
  assign blocked = valid_q && !ready_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      data_q    <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      if (load_i) begin
        // A transfer in the same cycle frees the slot for the new frame.
        if (blocked) begin
          overrun_q <= 1'b1;
        end else begin
          data_q  <= data_i;
          valid_q <= 1'b1;
        end
      end else if (xfer) begin
        valid_q <= 1'b0;
      end
    end
  end

  assign data_o    = data_q;
  assign valid_o   = valid_q;
  assign overrun_o = overrun_q;

endmodule

// File: rtl/mux_channel_scanner.sv
// Steps a 4:1 MUX through every channel, waits a settle time on each, samples
// its output and hands the assembled frame to a one-entry output register.
module mux_channel_scanner
  import mux_scanner_pkg::*;
#(
  parameter int NUM_CHANNELS  = DEF_NUM_CHANNELS,
  parameter int SEL_WIDTH     = DEF_SEL_WIDTH,
  parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES,
  parameter int CNT_WIDTH     = DEF_CNT_WIDTH
) (
  input  logic                    Clock_In,
  input  logic                    Reset_In,
  input  logic                    Start_In,
  input  logic                    Continuous_In,
  input  logic                    MUX_Data_In,
  output logic [SEL_WIDTH-1:0]    Select_Out,
  output logic                    Enable_Out,
  output logic [NUM_CHANNELS-1:0] Frame_Data_Out,
  output logic                    Frame_Valid_Out,
  input  logic                    Frame_Ready_In,
  output logic                    Busy_Out,
  output logic                    Overrun_Out
);

  localparam logic [CNT_WIDTH-1:0] CNT_LOAD = CNT_WIDTH'(SETTLE_CYCLES);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);
  localparam logic [SEL_WIDTH-1:0] SEL_LAST = SEL_WIDTH'(NUM_CHANNELS - 1);
  localparam logic [SEL_WIDTH-1:0] SEL_ONE  = SEL_WIDTH'(1);
  // With no settle time every channel goes straight to its sample cycle.
  localparam scan_state_e CH_ENTRY = (SETTLE_CYCLES == 0) ? SAMPLE : SETTLE;

  scan_state_e             state_q;
  logic [SEL_WIDTH-1:0]    sel_q;
  logic                    en_q;
  logic                    busy_q;
  logic [CNT_WIDTH-1:0]    cnt_q;
  logic [NUM_CHANNELS-1:0] asm_q;
  logic [NUM_CHANNELS-1:0] asm_d;
  logic                    frame_done;

  // Assembly value including the bit being captured this cycle, so the
  // completed frame can be handed off on the same edge as the last sample.
  always_comb begin
    asm_d = asm_q;
    if (state_q == SAMPLE) asm_d[sel_q] = MUX_Data_In;
  end

  assign frame_done = (state_q == SAMPLE) && (sel_q == SEL_LAST);

  always_ff @(posedge Clock_In) begin
    if (Reset_In) begin
      state_q <= IDLE;
      sel_q   <= '0;
      en_q    <= 1'b0;
      busy_q  <= 1'b0;
      cnt_q   <= '0;
      asm_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (Start_In) begin
            state_q <= CH_ENTRY;
            sel_q   <= '0;
            en_q    <= 1'b1;
            busy_q  <= 1'b1;
            cnt_q   <= CNT_LOAD;
          end
        end
        SETTLE: begin
          cnt_q <= cnt_q - CNT_ONE;
          if (cnt_q <= CNT_ONE) state_q <= SAMPLE;
        end
        SAMPLE: begin
          asm_q <= asm_d;
          if (sel_q != SEL_LAST) begin
            state_q <= CH_ENTRY;
            sel_q   <= sel_q + SEL_ONE;
            cnt_q   <= CNT_LOAD;
          end else if (Continuous_In) begin
            state_q <= CH_ENTRY;
            sel_q   <= '0;
            cnt_q   <= CNT_LOAD;
          end else begin
            state_q <= IDLE;
            sel_q   <= '0;
            en_q    <= 1'b0;
            busy_q  <= 1'b0;
            cnt_q   <= '0;
          end
        end
        default: begin
          state_q <= IDLE;
          sel_q   <= '0;
          en_q    <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  frame_hold_register #(
    .W(NUM_CHANNELS)
  ) u_hold (
    .clk_i     (Clock_In),
    .rst_i     (Reset_In),
    .load_i    (frame_done),
    .data_i    (asm_d),
    .ready_i   (Frame_Ready_In),
    .data_o    (Frame_Data_Out),
    .valid_o   (Frame_Valid_Out),
    .overrun_o (Overrun_Out)
  );

  assign Select_Out = sel_q;
  assign Enable_Out = en_q;
  assign Busy_Out   = busy_q;

endmodule

// File: tb/tb_mux_channel_scanner.sv
// Bench for mux_channel_scanner: default build plus a zero-settle build,
// table-driven single scans, scoreboarded frame transfers and corner cases.
module tb_mux_channel_scanner;

  logic       clk = 1'b0;
  logic       rst;
  logic       start, cont, ready;
  logic [3:0] ch;
  logic       mux;
  logic [1:0] sel;
  logic       en, valid, busy, ovr;
  logic [3:0] fdata;

  logic       start1, ready1;
  logic [3:0] ch1;
  logic       mux1;
  logic [1:0] sel1;
  logic       en1, valid1, busy1, ovr1;
  logic [3:0] fdata1;

  int         checks = 0;
  int         errors = 0;
  int         cyc    = 0;
  logic [3:0] exp_q[$];

  always #5 clk = ~clk;

  // Behavioural 4:1 MUX; output forced low while disabled.
  assign mux  = en  ? ch[sel]   : 1'b0;
  assign mux1 = en1 ? ch1[sel1] : 1'b0;

  mux_channel_scanner dut (
    .Clock_In(clk), .Reset_In(rst), .Start_In(start), .Continuous_In(cont),
    .MUX_Data_In(mux), .Select_Out(sel), .Enable_Out(en),
    .Frame_Data_Out(fdata), .Frame_Valid_Out(valid), .Frame_Ready_In(ready),
    .Busy_Out(busy), .Overrun_Out(ovr)
  );

  mux_channel_scanner #(.SETTLE_CYCLES(0)) dut0 (
    .Clock_In(clk), .Reset_In(rst), .Start_In(start1), .Continuous_In(1'b0),
    .MUX_Data_In(mux1), .Select_Out(sel1), .Enable_Out(en1),
    .Frame_Data_Out(fdata1), .Frame_Valid_Out(valid1), .Frame_Ready_In(ready1),
    .Busy_Out(busy1), .Overrun_Out(ovr1)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s (cycle %0d): got %h want %h", name, cyc, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Scoreboard: every handshake on the default build pops one expected frame.
  always @(negedge clk) begin
    if (!rst && valid && ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_frame (cycle %0d): got %h want none", cyc, fdata);
      end else begin
        logic [3:0] e;
        e = exp_q.pop_front();
        if (fdata !== e) begin
          errors++;
          $display("FAIL frame_data (cycle %0d): got %h want %h", cyc, fdata, e);
        end
      end
    end
  end

  // Single scan on the default build, optionally with a stray Start mid-scan.
  task automatic run_single(input logic [3:0] pat, input logic [3:0] exp, input int extra);
    ch = pat; cont = 1'b0; ready = 1'b1;
    exp_q.push_back(exp);
    start = 1'b1;
    tick(); cyc = 1;
    for (int c = 1; c <= 12; c++) begin
      chk("scan_sel_en_busy_valid", {sel, en, busy, valid},
          {2'((c - 1) / 3), 1'b1, 1'b1, 1'b0});
      start = (c == extra);
      tick();
    end
    start = 1'b0;
    chk("valid_at_13", {valid, busy, en}, 3'b100);
    tick();
    chk("valid_drops_14", {valid, busy, en, sel}, 5'b0);
  endtask

  typedef struct {
    logic [3:0] pat;
    logic [3:0] exp;
    int         extra;
  } vec_t;
  vec_t tbl[4];

  initial begin
    tbl[0] = '{pat: 4'b1101, exp: 4'b1101, extra: -1};
    tbl[1] = '{pat: 4'b0010, exp: 4'b0010, extra: -1};
    tbl[2] = '{pat: 4'b1000, exp: 4'b1000, extra: 4};
    tbl[3] = '{pat: 4'b0111, exp: 4'b0111, extra: -1};

    rst = 1'b1; start = 0; cont = 0; ready = 0; ch = 0;
    start1 = 0; ready1 = 0; ch1 = 0;
    tick(); tick();
    chk("reset_state", {sel, en, fdata, valid, busy, ovr}, 10'b0);
    rst = 1'b0;
    tick();

    // Table-driven single scans (includes a Start pulse while busy).
    for (int i = 0; i < 4; i++) begin
      run_single(tbl[i].pat, tbl[i].exp, tbl[i].extra);
      tick();
    end

    // Continuous with backpressure: second frame dropped, overrun latched.
    ch = 4'b1101; cont = 1'b1; ready = 1'b0;
    exp_q.push_back(4'b1101);
    start = 1'b1; tick(); cyc = 1; start = 1'b0;
    while (cyc < 13) tick();
    chk("cont_first_held", {valid, fdata, ovr}, {1'b1, 4'b1101, 1'b0});
    ch = 4'b0010;
    while (cyc < 25) tick();
    chk("overrun_set", {ovr, valid, fdata}, {1'b1, 1'b1, 4'b1101});
    chk("sel_wrapped", {sel, en, busy}, {2'd0, 1'b1, 1'b1});
    ready = 1'b1; tick(); ready = 1'b0;
    chk("overrun_sticky", {ovr, valid}, 2'b10);
    cont = 1'b0; rst = 1'b1; tick(); rst = 1'b0;
    chk("reset_clears_overrun", {ovr, valid, busy, en}, 4'b0);
    tick();

    // Completion coincides with a transfer: new frame loads, no overrun.
    ch = 4'b1011; cont = 1'b1; ready = 1'b0;
    exp_q.push_back(4'b1011);
    start = 1'b1; tick(); cyc = 1; start = 1'b0;
    while (cyc < 13) tick();
    chk("simul_first_held", {valid, fdata}, {1'b1, 4'b1011});
    ch = 4'b0100;
    exp_q.push_back(4'b0100);
    exp_q.push_back(4'b0100);
    while (cyc < 24) tick();
    ready = 1'b1;
    tick();
    chk("simul_reload", {valid, fdata, ovr}, {1'b1, 4'b0100, 1'b0});
    cont = 1'b0;
    while (cyc < 37) tick();
    chk("third_frame", {valid, busy, ovr}, 3'b100);
    tick();
    chk("third_done", {valid, busy, en, ovr}, 4'b0);

    // Reset mid-scan aborts without ever raising Valid.
    ch = 4'b1111; ready = 1'b1;
    start = 1'b1; tick(); cyc = 1; start = 1'b0;
    while (cyc < 5) tick();
    rst = 1'b1; tick(); rst = 1'b0;
    chk("midscan_reset", {sel, en, fdata, valid, busy, ovr}, 10'b0);
    for (int i = 0; i < 14; i++) begin
      chk("no_valid_after_abort", {valid, busy}, 2'b0);
      tick();
    end
    run_single(4'b0101, 4'b0101, -1);
    tick();

    // Zero-settle build: one sample per cycle.
    ch1 = 4'b0110; ready1 = 1'b1;
    start1 = 1'b1; tick(); cyc = 1; start1 = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      chk("fast_sel", {sel1, en1, valid1}, {2'(c - 1), 1'b1, 1'b0});
      tick();
    end
    chk("fast_valid", {valid1, fdata1, busy1, ovr1}, {1'b1, 4'b0110, 1'b0, 1'b0});
    tick();
    chk("fast_valid_drop", {valid1, en1}, 2'b0);

    chk("scoreboard_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
